vx_wb_arbiter: RTL and testbench
================================

VX_WB_ARBITER -- requirements
Module: VX_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQS, default 5, giving the number of execute-unit commit requesters (ALU, LSU, CSR, FPU, GPU).
REQ-002 SHALL have parameter DATAW, default 64, giving the width of the commit payload per requester.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous and active-high.
REQ-005 SHALL have port valid_in, input, NUM_REQS bits, the per-requester commit valid.
REQ-006 SHALL have port data_in, input, NUM_REQS*DATAW bits, the per-requester payload; requester i occupies bits [i*DATAW +: DATAW].
REQ-007 SHALL have port ready_in, output, NUM_REQS bits, the per-requester accept.
REQ-008 SHALL have port valid_out, output, 1 bit, the GPR writeback valid.
REQ-009 SHALL have port data_out, output, DATAW bits, the granted payload.
REQ-010 SHALL have port sel_out, output, max(1,clog2(NUM_REQS)) bits, the index of the requester that produced data_out.
REQ-011 SHALL have port ready_out, input, 1 bit, the writeback accept.

Function
REQ-012 SHALL, each cycle, select one grant index among the asserted valid_in bits, round-robin, starting the search at priority pointer P and wrapping modulo NUM_REQS.
REQ-013 SHALL assert ready_in[g] only for the granted index g, and only when the skid entry is empty; all other ready_in bits SHALL be 0.
REQ-014 SHALL define a transfer on requester g as valid_in[g] && ready_in[g]; a transfer SHALL capture data_in slice g and sel g.
REQ-015 SHALL, on each transfer from g, update P to (g+1) mod NUM_REQS; P SHALL hold when no transfer occurs.
REQ-016 SHALL implement a two-entry output stage (output register plus skid register) with states EMPTY, ONE and TWO:
- EMPTY + transfer -> ONE.
- ONE + transfer + no drain -> TWO.
- ONE + drain + no transfer -> EMPTY.
- ONE + transfer + drain -> ONE, with the new data in the output register.
- TWO + drain -> ONE, with the skid entry moved to the output register.
- A drain is valid_out && ready_out.
REQ-017 SHALL assert valid_out exactly in states ONE and TWO; data_out and sel_out SHALL come only from the output register.
REQ-018 SHALL give a latency of 1 cycle from a transfer to valid_out when the stage is EMPTY, or when it is ONE and draining in the same cycle.
REQ-019 SHALL NOT combinationally depend on ready_out when computing ready_in; ready_in depends only on valid_in, P and state.
REQ-020 SHALL preserve transfer order: payloads leave data_out in the order they were accepted, with no loss or duplication.
REQ-021 SHALL hold data_out and sel_out stable while valid_out=1 and ready_out=0.
REQ-022 SHALL assert no ready_in bit when valid_in is all zero, and SHALL leave P unchanged in that case.
REQ-023 SHALL, when NUM_REQS=1, degenerate to a 2-entry skid buffer with sel_out tied to 0.

Reset
REQ-024 SHALL, while reset is asserted, force state EMPTY, P=0, valid_out=0, data_out=0, sel_out=0 and ready_in=0, independent of clk.
REQ-025 SHALL, on reset mid-operation, discard both buffered entries without emitting them.
REQ-026 SHALL grant requester 0 highest priority on the first cycle after reset deassertion.

Verification
REQ-027 Scenario: reset, then valid_in=5'b00001 with data 0xA, ready_out=1 -> ready_in=5'b00001; next cycle valid_out=1, data_out=0xA, sel_out=0.
REQ-028 Scenario: valid_in=5'b11111 held, ready_out=1 -> grants follow 0,1,2,3,4,0, one per cycle, and sel_out follows the same sequence one cycle later.
REQ-029 Scenario: ready_out=0, valid_in=5'b00110 -> requester 1 accepted, then requester 2 accepted, then ready_in=0 (TWO); after ready_out=1, outputs are sel 1 then sel 2.
REQ-030 Scenario: in state ONE, transfer and drain in the same cycle over 10 cycles -> state stays ONE and one output per cycle with no bubble.
REQ-031 Scenario: reset asserted asynchronously mid-cycle while in TWO -> valid_out drops immediately; after release, P=0 and no stale data appears.
REQ-032 Scenario: valid_in=5'b10000 only, then 5'b10001 -> requester 4 granted, P wraps to 0, then requester 0 granted.

Source files
------------

// File: rtl/vx_wb_arbiter_if.sv
// Commit-to-writeback bus: NUM_REQS requester lanes in, one GPR writeback lane out.
// "slave" is the arbiter's view, "master" is the surrounding pipeline's view.
interface vx_wb_arbiter_if #(
    parameter int NUM_REQS = 5,
    parameter int DATAW    = 64,
    localparam int SELW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
);
    logic [NUM_REQS-1:0]       valid_in;
    logic [NUM_REQS*DATAW-1:0] data_in;
    logic [NUM_REQS-1:0]       ready_in;
    logic                      valid_out;
    logic [DATAW-1:0]          data_out;
    logic [SELW-1:0]           sel_out;
    logic                      ready_out;

    modport slave (
        input  valid_in, data_in, ready_out,
        output ready_in, valid_out, data_out, sel_out
    );

    modport master (
        output valid_in, data_in, ready_out,
        input  ready_in, valid_out, data_out, sel_out
    );
endinterface

// File: rtl/vx_wb_arbiter.sv
// Round-robin writeback arbiter feeding a two-entry (output + skid) stage.
// ready_in never looks at ready_out, so the accept path is cut from the writeback stall.
module vx_wb_arbiter #(
    parameter int NUM_REQS = 5,
    parameter int DATAW    = 64,
    localparam int SELW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic clk,
    input  logic reset,
    vx_wb_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

    state_e            state_q;
    logic [SELW-1:0]   ptr_q;
    logic              valid_q;
    logic [DATAW-1:0]  out_data_q;
    logic [SELW-1:0]   out_sel_q;
    logic [DATAW-1:0]  skid_data_q;
    logic [SELW-1:0]   skid_sel_q;

    logic [NUM_REQS-1:0] hi_mask;
    logic [NUM_REQS-1:0] ready_d;
    logic                grant_vld;
    logic [SELW-1:0]     grant_idx;
    logic [DATAW-1:0]    grant_data;
    logic [SELW-1:0]     ptr_d;
    logic                xfer;
    logic                drain;

    // Requesters at or above the pointer win over those that wrapped around below it.
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_mask
        assign hi_mask[gi] = (SELW'(gi) >= ptr_q);
    end

    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (bus.valid_in[i]) begin
                grant_vld  = 1'b1;
                grant_idx  = SELW'(i);
                grant_data = bus.data_in[i*DATAW +: DATAW];
            end
        end
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (bus.valid_in[i] && hi_mask[i]) begin
                grant_idx  = SELW'(i);
                grant_data = bus.data_in[i*DATAW +: DATAW];
            end
        end
    end

    assign ptr_d = (grant_idx == SELW'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
    assign xfer  = grant_vld && (state_q != ST_TWO);
    assign drain = valid_q && bus.ready_out;

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_ready
        assign ready_d[gi] = !reset && xfer && (grant_idx == SELW'(gi));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            ptr_q       <= '0;
            valid_q     <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
        end else begin
            if (xfer) begin
                ptr_q <= ptr_d;
            end
            case (state_q)
                ST_EMPTY: begin
                    if (xfer) begin
                        state_q    <= ST_ONE;
                        valid_q    <= 1'b1;
                        out_data_q <= grant_data;
                        out_sel_q  <= grant_idx;
                    end
                end
                ST_ONE: begin
                    if (xfer && drain) begin
                        out_data_q <= grant_data;
                        out_sel_q  <= grant_idx;
                    end else if (xfer) begin
                        state_q     <= ST_TWO;
                        skid_data_q <= grant_data;
                        skid_sel_q  <= grant_idx;
                    end else if (drain) begin
                        state_q <= ST_EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        state_q    <= ST_ONE;
                        out_data_q <= skid_data_q;
                        out_sel_q  <= skid_sel_q;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_in  = ready_d;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = out_data_q;
    assign bus.sel_out   = out_sel_q;
endmodule

// File: tb/tb_vx_wb_arbiter.sv
// Directed bench for vx_wb_arbiter with five requesters and 64-bit payloads.
module tb_vx_wb_arbiter;
    logic clk;
    logic reset;
    int   passed;
    int   total;

    vx_wb_arbiter_if #(.NUM_REQS(5), .DATAW(64)) bus ();

    vx_wb_arbiter #(.NUM_REQS(5), .DATAW(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [63:0] v);
        bus.data_in[i*64 +: 64] = v;
    endtask

    task automatic do_reset();
        bus.valid_in  = '0;
        bus.ready_out = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.valid_in  = 5'b11111;
        bus.ready_out = 1'b1;
        for (int i = 0; i < 5; i++) set_data(i, 64'hDEAD_0000 + 64'(i));
        tick();
        tick();
        total++; if (bus.valid_out !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.valid_out); else passed++;
        total++; if (bus.data_out !== 64'h0) $display("FAIL reset_data: got %h expected 0", bus.data_out); else passed++;
        total++; if (bus.sel_out !== 3'd0) $display("FAIL reset_sel: got %0d expected 0", bus.sel_out); else passed++;
        total++; if (bus.ready_in !== 5'b00000) $display("FAIL reset_ready: got %b expected 00000", bus.ready_in); else passed++;
        bus.valid_in = '0;
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        bus.valid_in  = 5'b00001;
        bus.ready_out = 1'b1;
        set_data(0, 64'hA);
        #1;
        total++; if (bus.ready_in !== 5'b00001) $display("FAIL single_ready: got %b expected 00001", bus.ready_in); else passed++;
        tick();
        bus.valid_in = '0;
        #1;
        total++; if (bus.valid_out !== 1'b1) $display("FAIL single_valid: got %b expected 1", bus.valid_out); else passed++;
        total++; if (bus.data_out !== 64'hA) $display("FAIL single_data: got %h expected a", bus.data_out); else passed++;
        total++; if (bus.sel_out !== 3'd0) $display("FAIL single_sel: got %0d expected 0", bus.sel_out); else passed++;
        tick();
        total++; if (bus.valid_out !== 1'b0) $display("FAIL single_drained: got %b expected 0", bus.valid_out); else passed++;
        $display("test_single: sent 0xa on requester 0");
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 5; i++) set_data(i, 64'h100 + 64'(i));
        bus.valid_in  = 5'b11111;
        bus.ready_out = 1'b1;
        #1;
        for (int c = 0; c < 6; c++) begin
            total++;
            if (bus.ready_in !== (5'b00001 << (c % 5)))
                $display("FAIL rr_grant[%0d]: got %b expected %b", c, bus.ready_in, 5'b00001 << (c % 5));
            else passed++;
            if (c > 0) begin
                total++;
                if (bus.valid_out !== 1'b1 || bus.sel_out !== 3'((c - 1) % 5) || bus.data_out !== 64'h100 + 64'((c - 1) % 5))
                    $display("FAIL rr_out[%0d]: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h",
                             c, bus.valid_out, bus.sel_out, bus.data_out, (c - 1) % 5, 64'h100 + 64'((c - 1) % 5));
                else passed++;
            end
            tick();
        end
        bus.valid_in = '0;
        #1;
        total++; if (bus.sel_out !== 3'd0 || bus.valid_out !== 1'b1) $display("FAIL rr_last: got v=%b sel=%0d expected v=1 sel=0", bus.valid_out, bus.sel_out); else passed++;
        tick();
        $display("test_round_robin: six grants issued");
    endtask

    task automatic test_backpressure();
        do_reset();
        set_data(1, 64'h11);
        set_data(2, 64'h22);
        bus.valid_in  = 5'b00110;
        bus.ready_out = 1'b0;
        #1;
        total++; if (bus.ready_in !== 5'b00010) $display("FAIL bp_grant1: got %b expected 00010", bus.ready_in); else passed++;
        tick();
        total++; if (bus.ready_in !== 5'b00100) $display("FAIL bp_grant2: got %b expected 00100", bus.ready_in); else passed++;
        total++; if (bus.valid_out !== 1'b1 || bus.sel_out !== 3'd1) $display("FAIL bp_one: got v=%b sel=%0d expected v=1 sel=1", bus.valid_out, bus.sel_out); else passed++;
        tick();
        total++; if (bus.ready_in !== 5'b00000) $display("FAIL bp_full: got %b expected 00000", bus.ready_in); else passed++;
        tick();
        total++; if (bus.ready_in !== 5'b00000) $display("FAIL bp_full_hold: got %b expected 00000", bus.ready_in); else passed++;
        total++; if (bus.sel_out !== 3'd1 || bus.data_out !== 64'h11) $display("FAIL bp_stable: got sel=%0d data=%h expected sel=1 data=11", bus.sel_out, bus.data_out); else passed++;
        bus.valid_in  = '0;
        bus.ready_out = 1'b1;
        tick();
        total++; if (bus.valid_out !== 1'b1 || bus.sel_out !== 3'd2 || bus.data_out !== 64'h22) $display("FAIL bp_second: got v=%b sel=%0d data=%h expected v=1 sel=2 data=22", bus.valid_out, bus.sel_out, bus.data_out); else passed++;
        tick();
        total++; if (bus.valid_out !== 1'b0) $display("FAIL bp_empty: got %b expected 0", bus.valid_out); else passed++;
        $display("test_backpressure: drained sel 1 then sel 2");
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.ready_out = 1'b1;
        bus.valid_in  = 5'b00001;
        set_data(0, 64'h500);
        tick();
        for (int c = 1; c <= 10; c++) begin
            set_data(0, 64'h500 + 64'(c));
            #1;
            total++; if (bus.ready_in !== 5'b00001) $display("FAIL b2b_ready[%0d]: got %b expected 00001", c, bus.ready_in); else passed++;
            total++;
            if (bus.valid_out !== 1'b1 || bus.data_out !== 64'h500 + 64'(c - 1))
                $display("FAIL b2b_out[%0d]: got v=%b data=%h expected v=1 data=%h", c, bus.valid_out, bus.data_out, 64'h500 + 64'(c - 1));
            else passed++;
            tick();
        end
        bus.valid_in = '0;
        #1;
        total++; if (bus.data_out !== 64'h50A || bus.valid_out !== 1'b1) $display("FAIL b2b_tail: got v=%b data=%h expected v=1 data=50a", bus.valid_out, bus.data_out); else passed++;
        tick();
        total++; if (bus.valid_out !== 1'b0) $display("FAIL b2b_empty: got %b expected 0", bus.valid_out); else passed++;
        $display("test_back_to_back: ten streamed transfers");
    endtask

    task automatic test_async_reset();
        do_reset();
        set_data(0, 64'hC0);
        set_data(1, 64'hC1);
        bus.valid_in  = 5'b00011;
        bus.ready_out = 1'b0;
        tick();
        tick();
        total++; if (bus.valid_out !== 1'b1 || bus.ready_in !== 5'b00000) $display("FAIL ar_two: got v=%b ready=%b expected v=1 ready=00000", bus.valid_out, bus.ready_in); else passed++;
        #3;
        reset = 1'b1;
        #1;
        total++; if (bus.valid_out !== 1'b0) $display("FAIL ar_valid_drop: got %b expected 0", bus.valid_out); else passed++;
        total++; if (bus.data_out !== 64'h0 || bus.sel_out !== 3'd0) $display("FAIL ar_outputs: got data=%h sel=%0d expected data=0 sel=0", bus.data_out, bus.sel_out); else passed++;
        total++; if (bus.ready_in !== 5'b00000) $display("FAIL ar_ready: got %b expected 00000", bus.ready_in); else passed++;
        #1;
        reset = 1'b0;
        bus.valid_in  = '0;
        bus.ready_out = 1'b1;
        tick();
        tick();
        total++; if (bus.valid_out !== 1'b0) $display("FAIL ar_no_stale: got %b expected 0", bus.valid_out); else passed++;
        bus.valid_in = 5'b11111;
        #1;
        total++; if (bus.ready_in !== 5'b00001) $display("FAIL ar_ptr_zero: got %b expected 00001", bus.ready_in); else passed++;
        bus.valid_in = '0;
        $display("test_async_reset: two entries discarded");
    endtask

    task automatic test_wrap_and_idle();
        do_reset();
        set_data(0, 64'hE0);
        set_data(4, 64'hE4);
        bus.ready_out = 1'b1;
        bus.valid_in  = 5'b10000;
        #1;
        total++; if (bus.ready_in !== 5'b10000) $display("FAIL wrap_grant4: got %b expected 10000", bus.ready_in); else passed++;
        tick();
        bus.valid_in = 5'b10001;
        #1;
        total++; if (bus.ready_in !== 5'b00001) $display("FAIL wrap_grant0: got %b expected 00001", bus.ready_in); else passed++;
        total++; if (bus.sel_out !== 3'd4 || bus.data_out !== 64'hE4) $display("FAIL wrap_out4: got sel=%0d data=%h expected sel=4 data=e4", bus.sel_out, bus.data_out); else passed++;
        tick();
        bus.valid_in = '0;
        #1;
        total++; if (bus.sel_out !== 3'd0 || bus.data_out !== 64'hE0) $display("FAIL wrap_out0: got sel=%0d data=%h expected sel=0 data=e0", bus.sel_out, bus.data_out); else passed++;
        for (int c = 0; c < 3; c++) begin
            total++; if (bus.ready_in !== 5'b00000) $display("FAIL idle_ready[%0d]: got %b expected 00000", c, bus.ready_in); else passed++;
            tick();
        end
        bus.valid_in = 5'b11111;
        #1;
        total++; if (bus.ready_in !== 5'b00010) $display("FAIL idle_ptr_hold: got %b expected 00010", bus.ready_in); else passed++;
        bus.valid_in = '0;
        tick();
        $display("test_wrap_and_idle: pointer wrapped and held");
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        bus.valid_in  = '0;
        bus.data_in   = '0;
        bus.ready_out = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_wrap_and_idle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
